// File: rtl/nibble_ser_pkg.sv
// ============================================================================
//  Module  : nibble_ser_pkg
//  Brief   : Shared types, widths and sel-order helpers for nibble_ser_ctrl.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package nibble_ser_pkg;

    localparam int WORD_W = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic logic [SEL_W-1:0] sel_first(input logic msb_first);
        return {SEL_W{msb_first}};
    endfunction

    // Advance one bit position; 2-bit modulo arithmetic in either direction.
    function automatic logic [SEL_W-1:0] sel_next(input logic [SEL_W-1:0] cur,
                                                  input logic             msb_first);
        return msb_first ? (cur - SEL_W'(1)) : (cur + SEL_W'(1));
    endfunction

endpackage

`default_nettype wire

// File: rtl/nibble_fifo.sv
// ============================================================================
//  Module  : nibble_fifo
//  Brief   : Synchronous word FIFO, power-of-two DEPTH, async active-low reset.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module nibble_fifo
    import nibble_ser_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic [WORD_W-1:0]        push_data,
    input  logic                     pop,
    output logic [WORD_W-1:0]        pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;
    localparam logic [c_CW-1:0] c_FULL = c_CW'(DEPTH);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_AW-1:0]   r_rd_ptr;
    logic [c_CW-1:0]   r_count;

    // Storage is not reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            if (push && !pop) begin
                r_count <= r_count + c_CW'(1);
            end else if (pop && !push) begin
                r_count <= r_count - c_CW'(1);
            end
        end
    end

    assign pop_data = r_mem[r_rd_ptr];
    assign full     = (r_count == c_FULL);
    assign empty    = (r_count == '0);
    assign count    = r_count;

endmodule

`default_nettype wire

// File: rtl/nibble_ser_ctrl.sv
// ============================================================================
//  Module  : nibble_ser_ctrl
//  Brief   : Buffers 4-bit words and sequences sel/D for a registered 4:1 mux,
//            with q_valid/q_last aligned to the mux output.
//            Optional stall input enabled by NIBBLE_SER_CTRL_STALL_EN.
//  Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module nibble_ser_ctrl
    import nibble_ser_pkg::*;
#(
    parameter int DEPTH     = 2,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    output logic [SEL_W-1:0]  sel,
    output logic [WORD_W-1:0] D,
    output logic              q_valid,
    output logic              q_last,
    output logic              busy
`ifdef NIBBLE_SER_CTRL_STALL_EN
    ,
    input  logic              stall
`endif
);

    localparam logic [SEL_W-1:0] c_SEL_FIRST = sel_first(MSB_FIRST);
    localparam logic [1:0]       c_LAST_BIT  = 2'd3;

    state_t                    r_state;
    logic [1:0]                r_bitcnt;
    logic                      w_stall;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_shift_v;
    logic [WORD_W-1:0]         w_fifo_data;
    logic                      w_fifo_full;
    logic                      w_fifo_empty;
    logic [$clog2(DEPTH):0]    w_fifo_count;

`ifdef NIBBLE_SER_CTRL_STALL_EN
    assign w_stall = stall;
`else
    assign w_stall = 1'b0;
`endif

    assign in_ready = !w_fifo_full;
    assign w_push   = in_valid && in_ready;

    // A word is taken either to start from idle or to chain onto the last bit.
    assign w_pop = !w_fifo_empty && !w_stall &&
                   ((r_state == IDLE) || (r_bitcnt == c_LAST_BIT));

    assign w_shift_v = (r_state == SHIFT) && !w_stall;
    assign busy      = (r_state == SHIFT) || (w_fifo_count != '0);

    nibble_fifo #(
        .DEPTH     (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rstn      (rstn),
        .push      (w_push),
        .push_data (in_data),
        .pop       (w_pop),
        .pop_data  (w_fifo_data),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty),
        .count     (w_fifo_count)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_bitcnt <= 2'd0;
            sel      <= c_SEL_FIRST;
            D        <= '0;
            q_valid  <= 1'b0;
            q_last   <= 1'b0;
        end else begin
            q_valid <= w_shift_v;
            q_last  <= w_shift_v && (r_bitcnt == c_LAST_BIT);
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        D        <= w_fifo_data;
                        sel      <= c_SEL_FIRST;
                        r_bitcnt <= 2'd0;
                        r_state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (!w_stall) begin
                        if (r_bitcnt == c_LAST_BIT) begin
                            if (w_pop) begin
                                D        <= w_fifo_data;
                                sel      <= c_SEL_FIRST;
                                r_bitcnt <= 2'd0;
                            end else begin
                                r_state  <= IDLE;
                            end
                        end else begin
                            r_bitcnt <= r_bitcnt + 2'd1;
                            sel      <= sel_next(sel, MSB_FIRST);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/nibble_ser_ctrl.md
# nibble_ser_ctrl

Upstream sequencer for the registered 4:1 bit-select stage. It accepts 4-bit words over a valid/ready handshake and buffers them in a small FIFO. It presents each word on `D` and steps `sel` through the four bit positions, one per cycle, so the downstream registered mux emits the word serially. It also produces `q_valid`/`q_last` strobes aligned with the downstream registered output, so the consumer of the serial bit knows which cycles carry data.

## Interface
Parameters:
- `DEPTH`, 2: input FIFO depth in words; power of two, ≥ 2.
- `MSB_FIRST`, 0: 0 gives sel order 0,1,2,3 (D[0] first); 1 gives 3,2,1,0.

Ports:
- `clk`  in  1  clock; all state on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  upstream word valid.
- `in_ready`  out  1  FIFO can accept a word; equals !full (combinational from FIFO count).
- `in_data`  in  4  upstream word.
- `sel`  out  2  bit select to downstream mux; registered.
- `D`  out  4  word held for downstream mux; registered.
- `q_valid`  out  1  downstream registered output holds a valid bit this cycle; registered.
- `q_last`  out  1  with `q_valid`: the bit is the last of its word; registered.
- `busy`  out  1  FSM in SHIFT or FIFO non-empty.
- `stall`  in  1  present only with `NIBBLE_SER_CTRL_STALL_EN`.

## Operation
- FIFO push when `in_valid && in_ready`. Pop only by the FSM. Push and pop in the same cycle are both honoured, and the count is unchanged. `in_ready` is 0 when full, even if a pop occurs that cycle.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop into `D`, set `sel` = first index, clear `bitcnt`, go to SHIFT.
  - SHIFT: each cycle, `bitcnt` increments and `sel` advances (+1, or −1 when MSB_FIRST).
  - At `bitcnt`=3:
    - If the FIFO is non-empty, pop the next word into `D`, reset `sel` to the first index and `bitcnt` to 0, and stay in SHIFT. Words stream back-to-back with no gap.
    - Otherwise go to IDLE; `D` and `sel` hold their last values.
- `shift_v` (internal) = state is SHIFT. `q_valid` <= `shift_v`. `q_last` <= `shift_v && bitcnt==3`.
- `sel` arithmetic is 2-bit modulo, with no wrap beyond one word. `bitcnt` is 2 bits.
- Reset values:
  - `sel`=0 when MSB_FIRST=0, else 3.
  - `D`=0, `q_valid`=0, `q_last`=0.
  - State IDLE, FIFO empty (so `in_ready`=1), `busy`=0.
- Reset mid-word or with a non-empty FIFO: all data is discarded, and outputs take their reset values asynchronously.

## Timing
- Word pushed at edge N into an empty FIFO with the FSM idle:
  - `D`/`sel` are valid after edge N+1.
  - The downstream mux captures bit 0 at edge N+2; `q_valid`=1 after edge N+2.
  - `q_last` is high after edge N+5.
- Back-to-back words give `q_valid` continuously high for 4·k cycles, with `q_last` every 4th cycle.
- A pop at edge N frees the slot; `in_ready` rises after edge N.
- Latency from the in handshake to the first valid serial bit is 2 cycles (FIFO empty, FSM idle).

## Configuration
- `NIBBLE_SER_CTRL_STALL_EN` defined:
  - Adds the `stall` input.
  - While `stall`=1 in SHIFT, `sel`, `bitcnt`, `D` and the FIFO pop are frozen, and `shift_v`=0, so `q_valid` is 0 one cycle later.
  - In IDLE, `stall` blocks loading a word.
  - Pushes continue regardless of `stall`.
- Undefined: the port is absent and the block behaves as if `stall`=0.

## Structure
- Package `nibble_ser_pkg` holds:
  - the state enum (IDLE, SHIFT);
  - `WORD_W`=4 and `SEL_W`=2;
  - the function giving the first/next sel index from MSB_FIRST.
- Sub-module `nibble_fifo`: synchronous FIFO, parameter DEPTH, with push/pop/full/empty/count ports and async active-low reset.

## Test plan
- Reset, then push 4'b1010 with MSB_FIRST=0 -> `sel` 0,1,2,3 on consecutive cycles; the downstream bit sequence is 0,1,0,1; `q_valid` is high for 4 cycles starting 2 cycles after the push; `q_last` is on the 4th.
- MSB_FIRST=1, push 4'b1100 -> `sel` 3,2,1,0; bits 1,1,0,0.
- Push 3 words back-to-back (0x5, 0xA, 0xF) with DEPTH=2 -> `in_ready` drops when full; `q_valid` is high for 12 contiguous cycles; `q_last` at cycles 4, 8 and 12.
- Assert `rstn`=0 at the 2nd bit of a word with one word queued -> `q_valid`/`q_last`/`D` go to 0 immediately; after release, no bits are emitted and `busy`=0.
- Simultaneous push and pop with FIFO count 1 -> count stays 1, and the next word streams with no gap.
- With `NIBBLE_SER_CTRL_STALL_EN`, stall for 3 cycles after bit 1 -> `sel` holds at 1; `q_valid` is 0 for 3 cycles; the remaining bits resume and all 4 bits are delivered in order.
